// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stall, HI/LO divider occupancy stall, taken-branch flush.
// Optional HAZARD_PERF_CNT_EN adds stall_cycles / flush_count performance counters.
module hazard_control_unit #(
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic       ID_uses_rt,
  input  logic       ID_hilo_use,
  input  logic [4:0] EX_rd,
  input  logic       EX_MemRead,
  input  logic       EX_div_start,
  input  logic       EX_branch_taken,
  output logic       PCWrite,
  output logic       IF_ID_Write,
  output logic       ID_EX_Bubble,
  output logic       IF_ID_Flush,
  output logic       div_busy,
  output logic [1:0] hz_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  typedef enum logic [1:0] {
    HZ_RUN       = 2'd0,
    HZ_STALL_LU  = 2'd1,
    HZ_STALL_DIV = 2'd2,
    HZ_FLUSH     = 2'd3
  } hz_e;

  hz_e              action_c;
  hz_e              hz_state_q, hz_state_d;
  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic             load_use_c;
  logic             div_busy_c;
  logic             div_hz_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hz_state_q <= HZ_RUN;
      div_cnt_q  <= '0;
    end else begin
      hz_state_q <= hz_state_d;
      div_cnt_q  <= div_cnt_d;
    end
  end

  // Hazard detection and single-action priority select
  always_comb begin
    load_use_c = EX_MemRead && (EX_rd != 5'd0) &&
                 ((EX_rd == ID_rs) || (ID_uses_rt && (EX_rd == ID_rt)));
    div_busy_c = (div_cnt_q != '0);
    div_hz_c   = div_busy_c && ID_hilo_use;

    action_c = HZ_RUN;
    if (EX_branch_taken)  action_c = HZ_FLUSH;
    else if (div_hz_c)    action_c = HZ_STALL_DIV;
    else if (load_use_c)  action_c = HZ_STALL_LU;

    hz_state_d = action_c;

    div_cnt_d = div_cnt_q;
    if (div_busy_c)        div_cnt_d = div_cnt_q - CNT_W'(1);
    else if (EX_div_start) div_cnt_d = CNT_W'(DIV_CYCLES);
  end

  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Bubble = 1'b0;
    IF_ID_Flush  = 1'b0;
    div_busy     = div_busy_c;
    hz_state     = hz_state_q;

    case (action_c)
      HZ_FLUSH: begin
        IF_ID_Flush  = 1'b1;
        ID_EX_Bubble = 1'b1;
      end
      HZ_STALL_DIV, HZ_STALL_LU: begin
        PCWrite      = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Bubble = 1'b1;
      end
      default: ;
    endcase

    // Pipeline frozen with NOPs injected while reset is held
    if (rst) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
      IF_ID_Flush  = 1'b1;
      div_busy     = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if ((action_c == HZ_STALL_LU) || (action_c == HZ_STALL_DIV))
      stall_cycles_d = stall_cycles_q + 32'd1;
    if (action_c == HZ_FLUSH)
      flush_count_d = flush_count_q + 32'd1;
    stall_cycles = stall_cycles_q;
    flush_count  = flush_count_q;
  end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Randomized bench for hazard_control_unit against a cycle-indexed behavioural model.
module tb_hazard_control_unit;

  localparam int unsigned DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] ID_rs = '0, ID_rt = '0, EX_rd = '0;
  logic       ID_uses_rt = 0, ID_hilo_use = 0, EX_MemRead = 0;
  logic       EX_div_start = 0, EX_branch_taken = 0;
  logic       PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, div_busy;
  logic [1:0] hz_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  hazard_control_unit #(.DIV_CYCLES(DIV), .CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt), .ID_hilo_use(ID_hilo_use),
    .EX_rd(EX_rd), .EX_MemRead(EX_MemRead), .EX_div_start(EX_div_start),
    .EX_branch_taken(EX_branch_taken),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .ID_EX_Bubble(ID_EX_Bubble),
    .IF_ID_Flush(IF_ID_Flush), .div_busy(div_busy), .hz_state(hz_state)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: divider is busy for DIV cycles starting right after the edge that accepted it
  int cyc        = 0;
  int issue_edge = -1000;
  int m_prev     = 0;
  int m_act      = 0;
  int m_stalls   = 0;
  int m_flushes  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit m_busy();
    return (cyc >= issue_edge) && (cyc < issue_edge + int'(DIV));
  endfunction

  task automatic drive(input int rs, input int rt, input bit urt, input bit hilo,
                       input int rd, input bit mr, input bit ds, input bit br);
    ID_rs = 5'(rs); ID_rt = 5'(rt); ID_uses_rt = urt; ID_hilo_use = hilo;
    EX_rd = 5'(rd); EX_MemRead = mr; EX_div_start = ds; EX_branch_taken = br;
  endtask

  // Check current-cycle outputs, then advance one clock and update the model
  task automatic step();
    bit lu, dh;
    #1;
    lu = EX_MemRead && (EX_rd != 0) && ((EX_rd == ID_rs) || (ID_uses_rt && EX_rd == ID_rt));
    dh = m_busy() && ID_hilo_use;
    m_act = EX_branch_taken ? 3 : dh ? 2 : lu ? 1 : 0;
    check_eq("pcwrite",  32'(PCWrite),      32'(m_act == 0 || m_act == 3));
    check_eq("ifid_wr",  32'(IF_ID_Write),  32'(m_act == 0 || m_act == 3));
    check_eq("bubble",   32'(ID_EX_Bubble), 32'(m_act != 0));
    check_eq("flush",    32'(IF_ID_Flush),  32'(m_act == 3));
    check_eq("div_busy", 32'(div_busy),     32'(m_busy()));
    check_eq("hz_state", 32'(hz_state),     32'(m_prev));
`ifdef HAZARD_PERF_CNT_EN
    check_eq("stall_cycles", stall_cycles, 32'(m_stalls));
    check_eq("flush_count",  flush_count,  32'(m_flushes));
`endif
    @(posedge clk);
    if (m_act == 1 || m_act == 2) m_stalls++;
    if (m_act == 3) m_flushes++;
    cyc++;
    if (EX_div_start && !m_busy() && (cyc - 1 >= issue_edge + int'(DIV)))
      issue_edge = cyc;
    m_prev = m_act;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_pcwrite"}, 32'(PCWrite),      32'd0);
    check_eq({tag, "_ifid_wr"}, 32'(IF_ID_Write),  32'd0);
    check_eq({tag, "_bubble"},  32'(ID_EX_Bubble), 32'd1);
    check_eq({tag, "_flush"},   32'(IF_ID_Flush),  32'd1);
    check_eq({tag, "_busy"},    32'(div_busy),     32'd0);
    check_eq({tag, "_hzstate"}, 32'(hz_state),     32'd0);
`ifdef HAZARD_PERF_CNT_EN
    check_eq({tag, "_stalls"},  stall_cycles,      32'd0);
    check_eq({tag, "_flushes"}, flush_count,       32'd0);
`endif
  endtask

  initial begin
    #12;
    check_reset_outputs("rst_init");
    @(negedge clk);
    rst = 1'b0;

    // Load-use on rs: one stall then RUN
    drive(5, 0, 0, 0, 5, 1, 0, 0); step();
    drive(5, 0, 0, 0, 9, 0, 0, 0); step();
    // Load to $0 never stalls
    drive(0, 0, 1, 0, 0, 1, 0, 0); step();
    // Load-use on rt only when rt is read
    drive(1, 7, 0, 0, 7, 1, 0, 0); step();
    drive(1, 7, 1, 0, 7, 1, 0, 0); step();
    // Divider occupancy with mfhi held
    drive(0, 0, 0, 0, 0, 0, 1, 0); step();
    for (int i = 0; i < 6; i++) begin
      drive(2, 3, 1, 1, 0, 0, 0, 0); step();
    end
    // Flush overrides both stalls; divider keeps counting
    drive(0, 0, 0, 0, 0, 0, 1, 0); step();
    drive(5, 0, 0, 1, 5, 1, 0, 1); step();
    drive(5, 0, 0, 1, 5, 1, 0, 0); step();
    // Mid-count reset: busy and state clear without a clock edge
    drive(0, 0, 0, 1, 5, 1, 0, 0); step();
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    issue_edge = -1000; m_prev = 0; m_stalls = 0; m_flushes = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0); step();

    // Randomized traffic with register fields narrowed to provoke matches
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
            ($urandom_range(0, 2) != 0), $urandom_range(0, 3), 1'($urandom),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
